branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of 2-bit counters; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL have parameter IDX_W, default 4, equal to log2(ENTRIES).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be on the rising edge of clk_i.
REQ-004 The block SHALL have port clk_i, input, 1, system clock.
REQ-005 The block SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port pred_req_i, input, 1, fetch requests a prediction for a branch at pc_i.
REQ-007 The block SHALL have port pc_i, input, 32, fetch PC of the branch.
REQ-008 The block SHALL have port flush_i, input, 1, pipeline flush that discards the in-flight prediction.
REQ-009 The block SHALL have port pred_valid_o, output, 1, prediction result valid.
REQ-010 The block SHALL have port pred_taken_o, output, 1, predicted direction (1 = taken).
REQ-011 The block SHALL have port pred_idx_o, output, IDX_W, table index used, carried down the pipe for update.
REQ-012 The block SHALL have port upd_valid_i, input, 1, a conditional branch resolved this cycle.
REQ-013 The block SHALL have port upd_idx_i, input, IDX_W, index returned with the resolved branch.
REQ-014 The block SHALL have port upd_taken_i, input, 1, resolved outcome from the branch decision unit (branch_o).
REQ-015 The block SHALL have port upd_pred_i, input, 1, direction that was predicted for that branch.
REQ-016 The block SHALL have port mispredict_o, output, 1, one-cycle pulse when upd_taken_i differs from upd_pred_i.
REQ-017 The block SHALL have port branch_cnt_o, output, 32, count of resolved branches.
REQ-018 The block SHALL have port mispred_cnt_o, output, 32, count of mispredictions.

Function
REQ-019 Table index SHALL be pc_i[IDX_W+1:2]; bits [1:0] SHALL be ignored.
REQ-020 Each entry SHALL be a 2-bit saturating counter: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken; prediction SHALL be the counter MSB.
REQ-021 Prediction latency SHALL be exactly one cycle: pred_req_i sampled at edge N yields pred_valid_o/pred_taken_o/pred_idx_o valid after edge N, held for one cycle only.
REQ-022 pred_valid_o SHALL be 0 in any cycle following an edge where pred_req_i was 0.
REQ-023 flush_i high at an edge SHALL force pred_valid_o to 0 after that edge, overriding a simultaneous pred_req_i; table and counters SHALL be unaffected by flush_i.
REQ-024 On upd_valid_i at an edge, entry upd_idx_i SHALL increment (saturate at 11) if upd_taken_i = 1, else decrement (saturate at 00).
REQ-025 On upd_valid_i, branch_cnt_o SHALL increment by 1; if upd_taken_i != upd_pred_i, mispred_cnt_o SHALL increment by 1 and mispredict_o SHALL be 1 for the following cycle only.
REQ-026 Both 32-bit counters SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-027 A prediction lookup and an update to the same index at the same edge SHALL return the pre-update counter value; the update SHALL still be committed.
REQ-028 Updates to different indices SHALL be independent; back-to-back updates to the same index on consecutive edges SHALL each be applied.
REQ-029 upd_idx_i, upd_taken_i and upd_pred_i SHALL be ignored when upd_valid_i = 0.

Reset
REQ-030 While rst_n_i = 0, all table entries SHALL be 01, pred_valid_o, pred_taken_o, mispredict_o SHALL be 0, pred_idx_o SHALL be 0, both counters SHALL be 0, independent of clk_i.
REQ-031 Reset asserted mid-operation SHALL immediately discard any in-flight prediction and mispredict pulse; first valid prediction SHALL appear one edge after a request following reset release.

Verification
REQ-032 After reset, pred_req_i=1, pc_i=0x0000_0010 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_idx_o=4.
REQ-033 Two updates idx 4 taken=1 pred=0, then request pc 0x10 -> pred_taken_o=1; two mispredict_o pulses; branch_cnt_o=2, mispred_cnt_o=2.
REQ-034 Five taken updates to idx 7 then three not-taken -> entry 7 reaches 11, ends at 00 (prediction 0); a fourth not-taken leaves it 00.
REQ-035 Same edge: pred_req_i pc 0x1C (idx 7, entry 01) and update idx 7 taken -> pred_taken_o=0; following request -> pred_taken_o=1.
REQ-036 pred_req_i=1 with flush_i=1 -> pred_valid_o=0 next cycle; counters unchanged.
REQ-037 Preload mispred_cnt_o path to 0xFFFFFFFF by forcing, then one mispredicted update -> mispred_cnt_o stays 0xFFFFFFFF, mispredict_o still pulses; rst_n_i low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Bimodal direction predictor. It holds a table of ENTRIES 2-bit saturating
//   counters that is indexed by the word-aligned fetch PC. A lookup returns its
//   result one cycle after the request. Resolved branches train the table and
//   feed two saturating 32-bit statistics counters.
//
// Ports
//   clk_i          system clock (all state changes on the rising edge)
//   rst_n_i        asynchronous active-low reset
//   pred_req_i     lookup request for the branch at pc_i
//   pc_i[31:0]     fetch PC; bits [IDX_W+1:2] select the counter
//   flush_i        drops the prediction being looked up this cycle
//   pred_valid_o   prediction result valid (one-cycle)
//   pred_taken_o   predicted direction (counter MSB)
//   pred_idx_o     table index used, returned later with the update
//   upd_valid_i    a conditional branch resolved this cycle
//   upd_idx_i      index carried with the resolved branch
//   upd_taken_i    resolved direction
//   upd_pred_i     direction that was predicted for it
//   mispredict_o   one-cycle pulse after a mispredicted update
//   branch_cnt_o   resolved-branch count (saturating)
//   mispred_cnt_o  misprediction count (saturating)
//
// ENTRIES must be a power of two (minimum 4) and IDX_W must be log2(ENTRIES).
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pred_req_i,
    input  logic [31:0]      pc_i,
    input  logic             flush_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic             upd_pred_i,
    output logic             mispredict_o,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispred_cnt_o
);

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_MAX     = 2'b11;
    localparam logic [1:0] CNT_MIN     = 2'b00;

    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] req_idx;
    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [IDX_W-1:0] pred_idx_q;
    logic             mispredict_q;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispred_cnt_q;
    logic             is_mispredict;
    logic             unused_pc;

    assign req_idx       = pc_i[IDX_W+1:2];
    assign unused_pc     = ^{pc_i[31:IDX_W+2], pc_i[1:0]};
    assign is_mispredict = upd_valid_i && (upd_taken_i != upd_pred_i);

    // Counter table. The lookup register below samples table_q before this
    // block's non-blocking update lands, so a same-edge lookup of the index
    // being trained sees the old value while the update is still committed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_WEAK_NT;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                if (table_q[upd_idx_i] != CNT_MAX) begin
                    table_q[upd_idx_i] <= table_q[upd_idx_i] + 2'd1;
                end
            end else begin
                if (table_q[upd_idx_i] != CNT_MIN) begin
                    table_q[upd_idx_i] <= table_q[upd_idx_i] - 2'd1;
                end
            end
        end
    end

    // Lookup stage. The result is only valid for the cycle after a request.
    // Direction and index are captured on any request, flushed or not,
    // because they are qualified by pred_valid_o downstream.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            pred_valid_q <= pred_req_i && !flush_i;
            if (pred_req_i) begin
                pred_taken_q <= table_q[req_idx][1];
                pred_idx_q   <= req_idx;
            end
        end
    end

    // Statistics. Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q <= is_mispredict;
            if (upd_valid_i && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (is_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_idx_o    = pred_idx_q;
    assign mispredict_o  = mispredict_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
